mem_wait_responder: RTL and testbench



---
 rtl/mem_wait_responder.sv | 126 ++++++++++++
 tb/tb_mem_wait_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_wait_responder.sv
// Wait-state memory responder: word RAM plus a small MMIO block (cycle counter,
// scratch register, transaction counter) behind a req/ready handshake.
module mem_wait_responder #(
    parameter int unsigned     N           = 32,
    parameter int unsigned     DEPTH       = 1024,
    parameter int unsigned     WAIT_CYCLES = 2,
    parameter logic [N-1:0]    MMIO_BASE   = N'(32'h0000_8000)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         wr_ena,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         ready,
    output logic         err,
    output logic [N-1:0] scratch_q
);

    localparam int unsigned  CNT_W     = 4;
    localparam int unsigned  AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [N-1:0] RAM_BYTES = N'(DEPTH * 4);
    localparam logic [N-1:0] SCR_ADDR  = MMIO_BASE + N'(4);
    localparam logic [N-1:0] TXN_ADDR  = MMIO_BASE + N'(8);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [N-1:0]       addr_q;
    logic [N-1:0]       din_q;
    logic               wr_q;
    logic [N-1:0]       cyc_cnt;
    logic [N-1:0]       txn_cnt;
    logic [N-1:0]       mem [DEPTH];

    logic [N-1:0]       acc_addr_c;
    logic [N-1:0]       acc_din_c;
    logic               acc_wr_c;
    logic               resp_c;
    logic [N-1:0]       rd_data_c;
    logic               err_c;
    logic               ram_we_c;
    logic               scr_we_c;
    logic [AW-1:0]      ram_idx_c;

    // With zero wait states the access happens on the accept edge, so it uses the live inputs.
    always_comb begin
        acc_addr_c = (state == S_IDLE) ? addr   : addr_q;
        acc_din_c  = (state == S_IDLE) ? din    : din_q;
        acc_wr_c   = (state == S_IDLE) ? wr_ena : wr_q;
        resp_c     = ((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (wait_cnt == '0));
        ram_idx_c  = acc_addr_c[AW+1:2];
        rd_data_c  = '0;
        err_c      = 1'b0;
        ram_we_c   = 1'b0;
        scr_we_c   = 1'b0;
        if (acc_addr_c[1:0] != 2'b00) begin
            err_c = 1'b1;
        end else if (acc_addr_c < RAM_BYTES) begin
            if (acc_wr_c) ram_we_c  = resp_c;
            else          rd_data_c = mem[ram_idx_c];
        end else if (acc_addr_c == MMIO_BASE) begin
            if (!acc_wr_c) rd_data_c = cyc_cnt;
        end else if (acc_addr_c == SCR_ADDR) begin
            if (acc_wr_c) scr_we_c  = resp_c;
            else          rd_data_c = scratch_q;
        end else if (acc_addr_c == TXN_ADDR) begin
            if (!acc_wr_c) rd_data_c = txn_cnt;
        end else begin
            err_c = 1'b1;
        end
    end

    // Handshake FSM, counters and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            wr_q      <= 1'b0;
            cyc_cnt   <= '0;
            txn_cnt   <= '0;
            dout      <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            scratch_q <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + N'(1);
            ready   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q   <= addr;
                        din_q    <= din;
                        wr_q     <= wr_ena;
                        wait_cnt <= CNT_W'(WAIT_CYCLES);
                        state    <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) state    <= S_RESP;
                    else                wait_cnt <= wait_cnt - CNT_W'(1);
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (resp_c) begin
                ready   <= 1'b1;
                dout    <= rd_data_c;
                err     <= err_c;
                txn_cnt <= txn_cnt + N'(1);
                if (scr_we_c) scratch_q <= acc_din_c;
            end
        end
    end

    // RAM array carries no reset; a reset on the response edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && ram_we_c) mem[ram_idx_c] <= acc_din_c;
    end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: a 2-wait-state instance and a 0-wait-state instance.
module tb_mem_wait_responder;

    localparam logic [31:0] MB = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr_ena, sel;
    logic [31:0] addr, din;
    logic [31:0] dout0, dout1, scr0, scr1;
    logic        ready0, ready1, err0, err1;
    logic        req0, req1;
    logic [31:0] dout_m, scr_m;
    logic        ready_m, err_m;

    int n_checks = 0;
    int n_pass   = 0;

    assign req0    = req & ~sel;
    assign req1    = req & sel;
    assign dout_m  = sel ? dout1  : dout0;
    assign ready_m = sel ? ready1 : ready0;
    assign err_m   = sel ? err1   : err0;
    assign scr_m   = sel ? scr1   : scr0;

    always #5 clk = ~clk;

    mem_wait_responder #(.N(32), .DEPTH(1024), .WAIT_CYCLES(2), .MMIO_BASE(MB)) u_dut2 (
        .clk(clk), .rst(rst), .req(req0), .wr_ena(wr_ena), .addr(addr), .din(din),
        .dout(dout0), .ready(ready0), .err(err0), .scratch_q(scr0)
    );

    mem_wait_responder #(.N(32), .DEPTH(1024), .WAIT_CYCLES(0), .MMIO_BASE(MB)) u_dut0 (
        .clk(clk), .rst(rst), .req(req1), .wr_ena(wr_ena), .addr(addr), .din(din),
        .dout(dout1), .ready(ready1), .err(err1), .scratch_q(scr1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One request; returns with the FSM back in IDLE. scramble alters inputs after accept.
    task automatic xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, output logic [31:0] rd, output logic e);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        req = 1'b1; wr_ena = we; addr = a; din = d;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk); #1;
            n = i;
            if (scramble && i == 1) begin
                addr = 32'h14; wr_ena = 1'b1; din = 32'hFFFF_FFFF;
            end
            if (ready_m) seen = 1'b1;
        end
        req = 1'b0;
        rd  = dout_m;
        e   = err_m;
        check("latency", 32'(n), sel ? 32'd1 : 32'd4);
        @(posedge clk); #1;
        check("ready_pulse", 32'(ready_m), 32'd0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [31:0] rd, r1, r2, r3;
    logic        e;
    int          pulses;

    initial begin
        rst = 1'b1; req = 1'b0; wr_ena = 1'b0; addr = '0; din = '0; sel = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_ready", 32'(ready_m), 32'd0);
        check("rst_dout", dout_m, 32'd0);
        check("rst_err", 32'(err_m), 32'd0);
        check("rst_scratch", scr_m, 32'd0);

        // RAM write then read
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, e);
        check("ram_wr_dout", rd, 32'd0);
        check("ram_wr_err", 32'(e), 32'd0);
        xfer(1'b0, 32'h10, 32'h0, 1'b0, rd, e);
        check("ram_rd_dout", rd, 32'hDEAD_BEEF);
        check("ram_rd_err", 32'(e), 32'd0);

        // Scratch register and transaction counter
        xfer(1'b1, MB + 32'd4, 32'h0000_00A5, 1'b0, rd, e);
        check("scr_q", scr_m, 32'h0000_00A5);
        xfer(1'b0, MB + 32'd4, 32'h0, 1'b0, rd, e);
        check("scr_rd", rd, 32'h0000_00A5);
        xfer(1'b0, MB + 32'd8, 32'h0, 1'b0, rd, e);
        check("txn_after4", rd, 32'd4);

        // Cycle counter spacing and ignored write
        xfer(1'b0, MB, 32'h0, 1'b0, r1, e);
        xfer(1'b0, MB, 32'h0, 1'b0, r2, e);
        check("cyc_delta", r2 - r1, 32'd5);
        xfer(1'b1, MB, 32'h1234, 1'b0, rd, e);
        check("cyc_wr_err", 32'(e), 32'd0);
        xfer(1'b0, MB, 32'h0, 1'b0, r3, e);
        check("cyc_delta2", r3 - r2, 32'd10);

        // Error decode
        xfer(1'b0, 32'h12, 32'h0, 1'b0, rd, e);
        check("misal_rd_err", 32'(e), 32'd1);
        check("misal_rd_dout", rd, 32'd0);
        xfer(1'b1, 32'h12, 32'h5555_5555, 1'b0, rd, e);
        check("misal_wr_err", 32'(e), 32'd1);
        xfer(1'b1, 32'h4000, 32'h6666_6666, 1'b0, rd, e);
        check("oob_wr_err", 32'(e), 32'd1);
        check("oob_wr_dout", rd, 32'd0);
        xfer(1'b0, 32'h4000, 32'h0, 1'b0, rd, e);
        check("oob_rd_err", 32'(e), 32'd1);
        xfer(1'b0, MB + 32'd12, 32'h0, 1'b0, rd, e);
        check("mmio_hole_err", 32'(e), 32'd1);
        xfer(1'b0, 32'h10, 32'h0, 1'b0, rd, e);
        check("ram_intact", rd, 32'hDEAD_BEEF);

        // Inputs changing after accept are ignored
        xfer(1'b1, 32'h14, 32'h1234_5678, 1'b0, rd, e);
        xfer(1'b0, 32'h10, 32'h0, 1'b1, rd, e);
        check("scramble_rd", rd, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h14, 32'h0, 1'b0, rd, e);
        check("scramble_nowr", rd, 32'h1234_5678);

        // Reset clears scratch and counters, not RAM
        pulse_rst();
        check("rst_scratch2", scr_m, 32'd0);
        xfer(1'b1, 32'h20, 32'hCAFE_0020, 1'b0, rd, e);
        xfer(1'b0, 32'h20, 32'h0, 1'b0, rd, e);
        check("ram20_rd", rd, 32'hCAFE_0020);
        xfer(1'b0, 32'h10, 32'h0, 1'b0, rd, e);
        check("ram_survives_rst", rd, 32'hDEAD_BEEF);
        xfer(1'b0, MB + 32'd8, 32'h0, 1'b0, rd, e);
        check("txn_after3", rd, 32'd3);

        // Reset during WAIT drops the pending write
        req = 1'b1; wr_ena = 1'b1; addr = 32'h20; din = 32'hBAD0_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 1'b0;
        pulse_rst();
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready_m) pulses++;
            @(posedge clk); #1;
        end
        check("rst_wait_noready", 32'(pulses), 32'd0);
        xfer(1'b0, 32'h20, 32'h0, 1'b0, rd, e);
        check("rst_wait_nowr", rd, 32'hCAFE_0020);

        // Zero wait states
        sel = 1'b1;
        xfer(1'b1, 32'h30, 32'h0000_0030, 1'b0, rd, e);
        check("w0_wr_err", 32'(e), 32'd0);
        xfer(1'b0, 32'h30, 32'h0, 1'b0, rd, e);
        check("w0_rd", rd, 32'h0000_0030);
        xfer(1'b0, 32'h31, 32'h0, 1'b0, rd, e);
        check("w0_misal_err", 32'(e), 32'd1);
        check("w0_misal_dout", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
